cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates completing functional-unit results onto the 3-lane common data bus that feeds the reorder buffer's complete port, the reservation stations and the map table. It does three things:
- Accepts up to `NUM_FU` valid/ready result requests per cycle.
- Grants at most `CDB_WIDTH` of them using rotating round-robin priority.
- Packs the grants into the low lanes and registers them onto the bus.

The ROB stops completing at the first invalid lane, so lane packing is mandatory.

## Interface
Parameters:
- `NUM_FU`, default 6: number of requesting functional units.
- `CDB_WIDTH`, default 3: number of bus lanes. It must match the ROB complete width.
- `ROBLEN`, default 32: number of ROB entries. The tag width is `$clog2(ROBLEN)`.

Ports:
- `clock`, input, 1: the single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low. When 0, all state clears immediately.
- `enable`, input, 1: when 0, nothing is granted this cycle.
- `squash_flag`, input, 1: mispredict flush.
- `fu_valid`, input, `NUM_FU`: request valid, one bit per FU.
- `fu_packet`, input, `NUM_FU` x `CDB_ROB_PACKET`: one result per FU, with fields tag, value, take_branch, NPC, halt.
- `fu_ready`, output, `NUM_FU`: grant. A result transfers when `fu_valid[i] & fu_ready[i]` is 1. This output is combinational.
- `CDB_packet_out`, output, `CDB_WIDTH` x `CDB_ROB_PACKET`: registered bus lanes, each with its own valid bit.

## Operation
Request rules:
- A requester holds `fu_valid` and `fu_packet` stable until it is granted.
- The arbiter never drops an accepted result, except on squash.

Selection:
- Scan FUs in the order `rr_ptr`, `rr_ptr+1`, … wrapping mod `NUM_FU`.
- Grant the first `min(CDB_WIDTH, number of valid requests)` valid FUs.
- `fu_ready` is 1 only for granted FUs.

Packing:
- The k-th grant in scan order goes to lane k.
- Lanes at index ≥ the grant count have valid = 0 and all fields 0.

Pointer update (`rr_ptr` width is `$clog2(NUM_FU)`):
- If at least one FU is granted, `rr_ptr` becomes (index of the last granted FU + 1) mod `NUM_FU`.
- If nothing is granted, `rr_ptr` is unchanged.

Fairness:
- A continuously valid FU is granted within `ceil(NUM_FU/CDB_WIDTH)` cycles.

`enable` = 0:
- `fu_ready` is all 0.
- Next cycle, every lane has valid = 0.
- `rr_ptr` holds.

`squash_flag` = 1:
- `fu_ready` is all 0 that cycle.
- Next cycle, every lane is cleared to valid = 0.
- `rr_ptr` becomes 0.
- Squash has priority over `enable`.
- FUs flush their own pending results.

Duplicate tags:
- Two FUs requesting with the same tag is illegal.
- Behaviour is undefined; this is checked by a bench assertion only.

## Timing
Reset:
- While `reset` = 0: every `CDB_packet_out` lane is all zero, `rr_ptr` is 0 and `fu_ready` is all 0.
- After `reset` rises, the first edge can register grants.

Latency:
- A grant in cycle t appears on `CDB_packet_out` in cycle t+1.
- An FU may present a new result in cycle t+1.
- Throughput is `CDB_WIDTH` results per cycle.

Boundary conditions:
- 0 valid requests: lanes invalid next cycle, pointer unchanged.
- Exactly `CDB_WIDTH` valid requests: all granted.
- More than `CDB_WIDTH` valid requests: the excess waits.
- The scan wraps from FU `NUM_FU-1` to FU 0.
- Squash and requests in the same cycle: the squash wins and nothing is granted.
- Reset asserted mid-operation clears the registered lanes asynchronously. The ROB ignores this because it is also in reset.

## Configuration
Macro `CDB_ARB_STATS_EN`.

When defined, the block adds two ports and two counters:
- `stat_grants`, output, 32: total granted results.
- `stat_conflict_cycles`, output, 32: cycles where (valid requests) > (grants) with `enable` = 1 and `squash_flag` = 0.
- Both counters reset to 0 and saturate at all ones.
- Squash does not clear them.

When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

## Structure
Shared definitions go in `sys_defs.svh`:
- Types: `CDB_ROB_PACKET`, `FU_CDB_REQ`.
- Constants: `` `NUM_FU ``, `` `CDB_WIDTH ``, `` `ROBLEN ``, `` `XLEN ``.

One sub-module, `cdb_rr_pick`:
- Combinational rotating-priority find-first-N.
- Inputs: request vector, `rr_ptr`.
- Outputs: grant vector, per-lane FU index, per-lane valid, last-grant index.

The top level holds the lane registers, `rr_ptr` and the optional counters.

## Test plan
1. Reset release, FUs 0-5 all valid with tags 1-6, `rr_ptr` = 0 → cycle 1: lanes carry tags 1,2,3; `fu_ready` = 000111; `rr_ptr` = 3. Cycle 2: lanes carry tags 4,5,6; `rr_ptr` = 0.
2. Only FU 4 valid (tag 9) → next cycle: lane0 = tag 9 with valid = 1; lanes 1 and 2 invalid; `rr_ptr` = 5.
3. `rr_ptr` = 5, FUs 5, 0 and 1 valid → grants in order 5, 0, 1 go to lanes 0-2 (wrap); `rr_ptr` = 2.
4. All FUs valid with `squash_flag` = 1 → `fu_ready` = 0; next-cycle lanes all invalid; `rr_ptr` = 0.
5. `enable` = 0 for 2 cycles with FUs 1 and 2 held valid → no grants. After `enable` = 1: lanes = FU1, FU2; FU packets held intact throughout.
6. With `CDB_ARB_STATS_EN`: 4 cycles of all 6 FUs valid → `stat_grants` = 12 and `stat_conflict_cycles` = 4. Without the macro, the design compiles with no stat ports.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB packet types, default sizes and a saturating adder
package cdb_arbiter_pkg;

    localparam int ARB_NUM_FU    = 6;
    localparam int ARB_CDB_WIDTH = 3;
    localparam int ARB_ROBLEN    = 32;
    localparam int XLEN          = 32;
    localparam int ARB_TAG_W     = $clog2(ARB_ROBLEN);

    typedef struct packed {
        logic                 valid;
        logic [ARB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
        logic [XLEN-1:0]      NPC;
        logic                 halt;
    } CDB_ROB_PACKET;

    typedef struct packed {
        logic          valid;
        CDB_ROB_PACKET packet;
    } FU_CDB_REQ;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// rtl/cdb_rr_pick.sv - rotating-priority find-first-N picker, packs grants into low lanes
module cdb_rr_pick #(
    parameter int NUM_FU    = 6,
    parameter int CDB_WIDTH = 3,
    parameter int PTR_W     = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]                req,
    input  logic [PTR_W-1:0]                 rr_ptr,
    output logic [NUM_FU-1:0]                grant,
    output logic [CDB_WIDTH-1:0][PTR_W-1:0]  lane_idx,
    output logic [CDB_WIDTH-1:0]             lane_valid,
    output logic [PTR_W-1:0]                 last_idx
);

    int cnt;
    int fu;

    always_comb begin
        grant      = '0;
        lane_idx   = '0;
        lane_valid = '0;
        last_idx   = '0;
        cnt        = 0;
        fu         = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            fu = int'(rr_ptr) + k;
            if (fu >= NUM_FU) begin
                fu = fu - NUM_FU;
            end
            // cnt doubles as the lane number of the next grant
            if (req[fu] && (cnt < CDB_WIDTH)) begin
                grant[fu]       = 1'b1;
                lane_idx[cnt]   = PTR_W'(fu);
                lane_valid[cnt] = 1'b1;
                last_idx        = PTR_W'(fu);
                cnt             = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with registered packed lanes; CDB_ARB_STATS_EN adds counters
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU    = ARB_NUM_FU,
    parameter int CDB_WIDTH = ARB_CDB_WIDTH,
    parameter int ROBLEN    = ARB_ROBLEN
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           squash_flag,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  CDB_ROB_PACKET [NUM_FU-1:0]     fu_packet,
    output logic [NUM_FU-1:0]              fu_ready,
    output CDB_ROB_PACKET [CDB_WIDTH-1:0]  CDB_packet_out
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_grants,
    output logic [31:0]                    stat_conflict_cycles
`endif
);

    localparam int PTR_W = $clog2(NUM_FU);
    localparam int TAG_W = $clog2(ROBLEN);

    logic [PTR_W-1:0]                 rr_ptr;
    logic [NUM_FU-1:0]                req;
    logic [NUM_FU-1:0]                grant;
    logic [CDB_WIDTH-1:0][PTR_W-1:0]  lane_idx;
    logic [CDB_WIDTH-1:0]             lane_valid;
    logic [PTR_W-1:0]                 last_idx;
    CDB_ROB_PACKET [CDB_WIDTH-1:0]    lane_nxt;

    // Reset is folded in so fu_ready stays low while the block is held in reset.
    assign req      = fu_valid & {NUM_FU{enable & ~squash_flag & reset}};
    assign fu_ready = grant;

    cdb_rr_pick #(
        .NUM_FU    (NUM_FU),
        .CDB_WIDTH (CDB_WIDTH),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .last_idx   (last_idx)
    );

    always_comb begin
        lane_nxt = '0;
        for (int l = 0; l < CDB_WIDTH; l++) begin
            if (lane_valid[l]) begin
                lane_nxt[l]       = fu_packet[lane_idx[l]];
                lane_nxt[l].tag   = fu_packet[lane_idx[l]].tag[TAG_W-1:0];
                lane_nxt[l].valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            CDB_packet_out <= '0;
            rr_ptr         <= '0;
        end else begin
            CDB_packet_out <= lane_nxt;
            if (squash_flag) begin
                rr_ptr <= '0;
            end else if (|grant) begin
                rr_ptr <= (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    int grant_cnt;
    int valid_cnt;

    always_comb begin
        grant_cnt = 0;
        valid_cnt = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            grant_cnt = grant_cnt + int'(grant[i]);
            valid_cnt = valid_cnt + int'(fu_valid[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_grants          <= '0;
            stat_conflict_cycles <= '0;
        end else begin
            stat_grants <= sat_add32(stat_grants, 32'(grant_cnt));
            if (enable && !squash_flag && (valid_cnt > grant_cnt)) begin
                stat_conflict_cycles <= sat_add32(stat_conflict_cycles, 32'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NF = ARB_NUM_FU;
    localparam int CW = ARB_CDB_WIDTH;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic                     squash_flag;
    logic [NF-1:0]            fu_valid;
    logic [NF-1:0]            fu_ready;
    CDB_ROB_PACKET [NF-1:0]   fu_packet;
    CDB_ROB_PACKET [CW-1:0]   cdb;
`ifdef CDB_ARB_STATS_EN
    logic [31:0]              stat_grants;
    logic [31:0]              stat_conflict_cycles;
`endif

    always #5 clock = ~clock;

    cdb_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .squash_flag    (squash_flag),
        .fu_valid       (fu_valid),
        .fu_packet      (fu_packet),
        .fu_ready       (fu_ready),
        .CDB_packet_out (cdb)
`ifdef CDB_ARB_STATS_EN
        ,
        .stat_grants          (stat_grants),
        .stat_conflict_cycles (stat_conflict_cycles)
`endif
    );

    int            checks = 0;
    int            errors = 0;
    int            m_ptr  = 0;
    int            tag_ctr = 0;
    CDB_ROB_PACKET exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic CDB_ROB_PACKET mk(input int t);
        CDB_ROB_PACKET p;
        p             = '0;
        p.tag         = ARB_TAG_W'(t);
        p.value       = $urandom;
        p.NPC         = $urandom;
        p.take_branch = 1'($urandom_range(0, 1));
        p.halt        = 1'($urandom_range(0, 1));
        return p;
    endfunction

    function automatic int fresh_tag();
        bit used;
        for (int n = 0; n < 40; n++) begin
            tag_ctr = (tag_ctr % 31) + 1;
            used = 1'b0;
            for (int f = 0; f < NF; f++) begin
                if (fu_valid[f] && (int'(fu_packet[f].tag) == tag_ctr)) used = 1'b1;
            end
            if (!used) return tag_ctr;
        end
        return tag_ctr;
    endfunction

    // Model the grant, push expected lanes, clock once, then compare what came out.
    task automatic cycle(input string name);
        logic [NF-1:0] er;
        int            cnt;
        int            f;
        int            last;
        CDB_ROB_PACKET l;
        #1;
        er = '0; cnt = 0; last = -1;
        for (int k = 0; k < NF; k++) begin
            f = (m_ptr + k) % NF;
            if (fu_valid[f] && enable && !squash_flag && cnt < CW) begin
                er[f] = 1'b1;
                l = fu_packet[f];
                l.valid = 1'b1;
                exp_q.push_back(l);
                cnt++;
                last = f;
            end
        end
        for (int k = cnt; k < CW; k++) exp_q.push_back('0);
        check({name, ".ready"}, 128'(fu_ready), 128'(er));
        if (squash_flag) m_ptr = 0;
        else if (last >= 0) m_ptr = (last + 1) % NF;
        @(posedge clock);
        #1;
        for (int j = 0; j < CW; j++) begin
            check($sformatf("%s.lane%0d", name, j), 128'(cdb[j]), 128'(exp_q.pop_front()));
        end
        check({name, ".ptr"}, 128'(dut.rr_ptr), 128'(m_ptr));
        for (int i = 0; i < NF; i++) if (er[i]) fu_valid[i] = 1'b0;
    endtask

    always @(posedge clock) begin
        for (int i = 0; i < NF; i++) begin
            for (int j = i + 1; j < NF; j++) begin
                assert (!(reset && fu_valid[i] && fu_valid[j] && fu_packet[i].tag == fu_packet[j].tag))
                    else $error("duplicate tag %0d on FU %0d and FU %0d", fu_packet[i].tag, i, j);
            end
        end
    end

    initial begin
        CDB_ROB_PACKET save1, save2;
        reset = 1'b0; enable = 1'b1; squash_flag = 1'b0;
        for (int i = 0; i < NF; i++) fu_packet[i] = mk(i + 1);
        fu_valid = '1;
        @(posedge clock); #1;
        check("rst.ready", 128'(fu_ready), 128'(0));
        check("rst.lanes", 128'(cdb), 128'(0));
        check("rst.ptr", 128'(dut.rr_ptr), 128'(0));

        // all six valid, tags 1..6
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t1.ready_const", 128'(fu_ready), 128'(6'b000111));
        cycle("t1a");
        check("t1a.tags", 128'({cdb[2].tag, cdb[1].tag, cdb[0].tag}), 128'({5'd3, 5'd2, 5'd1}));
        check("t1a.ptr_const", 128'(dut.rr_ptr), 128'(3));
        cycle("t1b");
        check("t1b.tags", 128'({cdb[2].tag, cdb[1].tag, cdb[0].tag}), 128'({5'd6, 5'd5, 5'd4}));
        check("t1b.ptr_const", 128'(dut.rr_ptr), 128'(0));

        // zero requests: lanes invalid, pointer holds
        fu_valid = '0;
        cycle("t0");

        // single requester FU4
        fu_packet[4] = mk(9); fu_valid[4] = 1'b1;
        cycle("t2");
        check("t2.lane0", 128'({cdb[0].valid, cdb[0].tag}), 128'({1'b1, 5'd9}));
        check("t2.lane12_valid", 128'({cdb[2].valid, cdb[1].valid}), 128'(0));
        check("t2.ptr_const", 128'(dut.rr_ptr), 128'(5));

        // wrap from FU5 to FU0
        fu_packet[5] = mk(10); fu_packet[0] = mk(11); fu_packet[1] = mk(12);
        fu_valid = 6'b100011;
        cycle("t3");
        check("t3.tags", 128'({cdb[2].tag, cdb[1].tag, cdb[0].tag}), 128'({5'd12, 5'd11, 5'd10}));
        check("t3.ptr_const", 128'(dut.rr_ptr), 128'(2));

        // squash beats requests
        for (int i = 0; i < NF; i++) fu_packet[i] = mk(13 + i);
        fu_valid = '1; squash_flag = 1'b1;
        cycle("t4");
        check("t4.valids", 128'({cdb[2].valid, cdb[1].valid, cdb[0].valid}), 128'(0));
        squash_flag = 1'b0; fu_valid = '0;

        // enable low holds FU1/FU2
        fu_packet[1] = mk(20); fu_packet[2] = mk(21);
        save1 = fu_packet[1]; save2 = fu_packet[2];
        fu_valid = 6'b000110; enable = 1'b0;
        cycle("t5a");
        cycle("t5b");
        enable = 1'b1;
        cycle("t5c");
        save1.valid = 1'b1; save2.valid = 1'b1;
        check("t5.lane0_const", 128'(cdb[0]), 128'(save1));
        check("t5.lane1_const", 128'(cdb[1]), 128'(save2));

        // random traffic with held requests
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NF; i++) begin
                if (!fu_valid[i] && $urandom_range(0, 1) == 1) begin
                    fu_packet[i] = mk(fresh_tag());
                    fu_valid[i]  = 1'b1;
                end
            end
            enable      = ($urandom_range(0, 3) != 0);
            squash_flag = ($urandom_range(0, 9) == 0);
            cycle("rnd");
            if (squash_flag) fu_valid = '0;
            squash_flag = 1'b0;
        end
        enable = 1'b1;

        // asynchronous reset between edges
        for (int i = 0; i < NF; i++) begin
            if (!fu_valid[i]) begin
                fu_packet[i] = mk(fresh_tag());
                fu_valid[i]  = 1'b1;
            end
        end
        #2 reset = 1'b0;
        #1;
        check("arst.lanes", 128'(cdb), 128'(0));
        check("arst.ptr", 128'(dut.rr_ptr), 128'(0));
        check("arst.ready", 128'(fu_ready), 128'(0));
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0;
        exp_q.delete();

`ifdef CDB_ARB_STATS_EN
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NF; i++) begin
                if (!fu_valid[i]) begin
                    fu_packet[i] = mk(fresh_tag());
                    fu_valid[i]  = 1'b1;
                end
            end
            cycle("stat");
        end
        check("stat.grants", 128'(stat_grants), 128'(12));
        check("stat.conflicts", 128'(stat_conflict_cycles), 128'(4));
`endif

        fu_valid = '0;
        cycle("end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
